// File: rtl/la_iopoc_pkg.sv
// -----------------------------------------------------------------------------
// la_iopoc_pkg
// Shared definitions for the IO ring power-on-control sequencer:
//   - state_t       : sequencer states
//   - PDN/HOLD/IE/OE: bit positions inside the io-ring control word
//   - CTRL_*        : 4-bit control word {oe, ie, hold, pdn} driven in each state
//   - ctrl_word()   : state -> control word lookup
// -----------------------------------------------------------------------------
package la_iopoc_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SETTLE = 3'd1,
        ST_UNHOLD = 3'd2,
        ST_ON     = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    localparam int PDN  = 0;
    localparam int HOLD = 1;
    localparam int IE   = 2;
    localparam int OE   = 3;

    // {oe, ie, hold, pdn}
    localparam logic [3:0] CTRL_OFF    = 4'b0011;
    localparam logic [3:0] CTRL_SETTLE = 4'b0010;
    localparam logic [3:0] CTRL_UNHOLD = 4'b0100;
    localparam logic [3:0] CTRL_ON     = 4'b1100;
    localparam logic [3:0] CTRL_DRAIN  = 4'b0110;

    function automatic logic [3:0] ctrl_word(input state_t s);
        case (s)
            ST_OFF:    return CTRL_OFF;
            ST_SETTLE: return CTRL_SETTLE;
            ST_UNHOLD: return CTRL_UNHOLD;
            ST_ON:     return CTRL_ON;
            ST_DRAIN:  return CTRL_DRAIN;
            default:   return CTRL_OFF;
        endcase
    endfunction

endpackage

// File: rtl/la_iopocsync.sv
// -----------------------------------------------------------------------------
// la_iopocsync
// Parameterised 2-flop synchronizer with synchronous active-high reset.
// Flops reset to 0 so every synchronised request reads as inactive after reset.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high reset
//   d     - asynchronous inputs [W-1:0]
//   q     - synchronised outputs [W-1:0]
// -----------------------------------------------------------------------------
module la_iopocsync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/la_iopocctrl.sv
// -----------------------------------------------------------------------------
// la_iopocctrl
// Power-on sequencer for one IO ring segment. Walks the ring through
// OFF -> SETTLE -> UNHOLD -> ON on power-up and ON -> DRAIN -> OFF on
// power-down so that hold/isolation always brackets output-enable changes.
// Any supply loss outside OFF forces OFF immediately and latches fault,
// which must be acknowledged by sampling en low in OFF.
//
// Optional build macro: LA_IOPOC_SYNC_EN
//   defined   - en, vdd_good, vddio_good pass through 2-flop synchronizers
//               (all response latencies grow by 2 cycles)
//   undefined - inputs are assumed synchronous to clk and used directly
//
// Ports:
//   clk        - always-on sequencer clock
//   reset      - synchronous active-high reset
//   en         - 1 requests power-up, 0 requests orderly power-down
//   vdd_good   - core supply good
//   vddio_good - IO supply good
//   ioring     - control word [0]=pdn [1]=hold [2]=ie [3]=oe, upper bits 0
//   ready      - ring fully on
//   busy       - sequencing in progress (SETTLE, UNHOLD, DRAIN)
//   fault      - sticky supply-loss indication
// -----------------------------------------------------------------------------
module la_iopocctrl
    import la_iopoc_pkg::*;
#(
    parameter int RINGW  = 8,
    parameter int PWRDLY = 16,
    parameter int ISODLY = 4,
    parameter int CW     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             vdd_good,
    input  logic             vddio_good,
    output logic [RINGW-1:0] ioring,
    output logic             ready,
    output logic             busy,
    output logic             fault
);

    // Elaboration-time parameter checks
    if (RINGW < 4) begin : g_chk_ringw
        $error("la_iopocctrl: RINGW must be >= 4");
    end
    if (PWRDLY < 1 || ISODLY < 1) begin : g_chk_dly
        $error("la_iopocctrl: PWRDLY and ISODLY must be >= 1");
    end
    if (CW < 1 || CW > 31) begin : g_chk_cw
        $error("la_iopocctrl: CW must be in 1..31");
    end else if (PWRDLY > (2**CW) - 1 || ISODLY > (2**CW) - 1) begin : g_chk_cw_range
        $error("la_iopocctrl: CW too narrow for PWRDLY/ISODLY");
    end

    localparam logic [CW-1:0] PWR_LAST = CW'(PWRDLY - 1);
    localparam logic [CW-1:0] ISO_LAST = CW'(ISODLY - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic en_s;
    logic vdd_s;
    logic vddio_s;

`ifdef LA_IOPOC_SYNC_EN
    logic [2:0] sync_q;

    la_iopocsync #(
        .W (3)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({en, vdd_good, vddio_good}),
        .q     (sync_q)
    );

    assign en_s    = sync_q[2];
    assign vdd_s   = sync_q[1];
    assign vddio_s = sync_q[0];
`else
    assign en_s    = en;
    assign vdd_s   = vdd_good;
    assign vddio_s = vddio_good;
`endif

    logic pgood;
    assign pgood = vdd_s & vddio_s;

    state_t        state,   state_n;
    logic [CW-1:0] cnt,     cnt_n;
    logic          fault_n;
    logic [3:0]    ctrl;

    // Next-state logic. Supply loss outranks both en and counter expiry.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_n = state;
        fault_n = fault;
        cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

        if (state != ST_OFF && !pgood) begin
            state_n = ST_OFF;
            cnt_n   = '0;
            fault_n = 1'b1;
        end else begin
            case (state)
                ST_OFF: begin
                    cnt_n = '0;
                    if (!en_s) begin
                        fault_n = 1'b0;          // en low in OFF acknowledges fault
                    end else if (pgood && !fault) begin
                        state_n = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!en_s) begin
                        state_n = ST_OFF;
                        cnt_n   = '0;
                    end else if (cnt == PWR_LAST) begin
                        state_n = ST_UNHOLD;
                        cnt_n   = '0;
                    end
                end
                ST_UNHOLD: begin
                    if (!en_s) begin
                        state_n = ST_DRAIN;
                        cnt_n   = '0;
                    end else if (cnt == ISO_LAST) begin
                        state_n = ST_ON;
                        cnt_n   = '0;
                    end
                end
                ST_ON: begin
                    cnt_n = '0;
                    if (!en_s) begin
                        state_n = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Drain always completes so oe stays low ISODLY cycles
                    // before pdn rises, even if en returns mid-drain.
                    if (cnt == ISO_LAST) begin
                        state_n = ST_OFF;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = ST_OFF;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Outputs are flops loaded from the next state, so they change on the
    // same edge as the state register and never glitch.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge
        // values, independent of statement order.
        if (reset) begin
            state <= ST_OFF;
            cnt   <= '0;
            fault <= 1'b0;
            ctrl  <= CTRL_OFF;
            ready <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            fault <= fault_n;
            ctrl  <= ctrl_word(state_n);
            ready <= (state_n == ST_ON);
            busy  <= (state_n == ST_SETTLE) || (state_n == ST_UNHOLD) ||
                     (state_n == ST_DRAIN);
        end
    end

    always_comb begin
        ioring       = '0;
        ioring[PDN]  = ctrl[PDN];
        ioring[HOLD] = ctrl[HOLD];
        ioring[IE]   = ctrl[IE];
        ioring[OE]   = ctrl[OE];
    end

endmodule

// File: tb/tb_la_iopocctrl.sv
// -----------------------------------------------------------------------------
// tb_la_iopocctrl
// Table-driven bench for la_iopocctrl with default parameters
// (RINGW=8, PWRDLY=16, ISODLY=4). Each table row holds inputs for a number
// of cycles and then compares all outputs. Latencies that depend on input
// response carry an extra SL cycles when LA_IOPOC_SYNC_EN is defined.
// -----------------------------------------------------------------------------
module tb_la_iopocctrl;

`ifdef LA_IOPOC_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       vdd_good;
    logic       vddio_good;
    logic [7:0] ioring;
    logic       ready;
    logic       busy;
    logic       fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    la_iopocctrl #(
        .RINGW  (8),
        .PWRDLY (16),
        .ISODLY (4),
        .CW     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .vdd_good   (vdd_good),
        .vddio_good (vddio_good),
        .ioring     (ioring),
        .ready      (ready),
        .busy       (busy),
        .fault      (fault)
    );

    typedef struct {
        string      name;
        int         cycles;
        bit         rst;
        bit         en;
        bit         vg;
        bit         vig;
        logic [7:0] ior;
        bit         rdy;
        bit         bsy;
        bit         flt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input int cycles,
                                input bit rst, input bit e, input bit vg,
                                input bit vig, input logic [7:0] ior,
                                input bit rdy, input bit bsy, input bit flt);
        vec_t v;
        v.name = name; v.cycles = cycles;
        v.rst = rst; v.en = e; v.vg = vg; v.vig = vig;
        v.ior = ior; v.rdy = rdy; v.bsy = bsy; v.flt = flt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ordering monitor: oe must never rise on the edge where hold falls.
    logic [7:0] prev_ior = 8'h03;
    int         order_viol = 0;
    always @(negedge clk) begin
        if (!reset && prev_ior[1] && !ioring[1] && ioring[3] && !prev_ior[3])
            order_viol <= order_viol + 1;
        prev_ior <= ioring;
    end

    initial begin
        bit saw_unhold;

        reset      = 1'b1;
        en         = 1'b1;
        vdd_good   = 1'b1;
        vddio_good = 1'b1;

        //                 name           cycles    rst en vg vig  ioring rdy bsy flt
        vecs.push_back(mk("reset_hold",   2,        1, 1, 1, 1, 8'h03, 0, 0, 0));
        vecs.push_back(mk("pwrup_t20",    20 + SL,  0, 1, 1, 1, 8'h04, 0, 1, 0));
        vecs.push_back(mk("pwrup_t21",    1,        0, 1, 1, 1, 8'h0C, 1, 0, 0));
        vecs.push_back(mk("drain_entry",  1 + SL,   0, 0, 1, 1, 8'h06, 0, 1, 0));
        vecs.push_back(mk("drain_t3",     3,        0, 0, 1, 1, 8'h06, 0, 1, 0));
        vecs.push_back(mk("drain_t4",     1,        0, 0, 1, 1, 8'h03, 0, 0, 0));
        vecs.push_back(mk("settle_c10",   11 + SL,  0, 1, 1, 1, 8'h02, 0, 1, 0));
        vecs.push_back(mk("vddio_loss",   1 + SL,   0, 1, 1, 0, 8'h03, 0, 0, 1));
        vecs.push_back(mk("fault_block",  5,        0, 1, 1, 1, 8'h03, 0, 0, 1));
        vecs.push_back(mk("fault_clear",  1 + SL,   0, 0, 1, 1, 8'h03, 0, 0, 0));
        vecs.push_back(mk("reentry",      1 + SL,   0, 1, 1, 1, 8'h02, 0, 1, 0));
        vecs.push_back(mk("unhold_reach", 16,       0, 1, 1, 1, 8'h04, 0, 1, 0));
        vecs.push_back(mk("unhold_drop",  1 + SL,   0, 0, 1, 1, 8'h06, 0, 1, 0));
        vecs.push_back(mk("udrain_t3",    3,        0, 0, 1, 1, 8'h06, 0, 1, 0));
        vecs.push_back(mk("udrain_off",   1,        0, 0, 1, 1, 8'h03, 0, 0, 0));
        vecs.push_back(mk("mid_settle",   5 + SL,   0, 1, 1, 1, 8'h02, 0, 1, 0));
        vecs.push_back(mk("mid_reset",    1,        1, 1, 1, 1, 8'h03, 0, 0, 0));
        vecs.push_back(mk("pwrup_again",  21 + SL,  0, 1, 1, 1, 8'h0C, 1, 0, 0));
        vecs.push_back(mk("on_vdd_loss",  1 + SL,   0, 1, 1, 0, 8'h03, 0, 0, 1));
        vecs.push_back(mk("on_fault_clr", 1 + SL,   0, 0, 1, 1, 8'h03, 0, 0, 0));

        foreach (vecs[i]) begin
            reset      = vecs[i].rst;
            en         = vecs[i].en;
            vdd_good   = vecs[i].vg;
            vddio_good = vecs[i].vig;
            repeat (vecs[i].cycles) @(negedge clk);
            check({vecs[i].name, ".ioring"}, 32'(ioring), 32'(vecs[i].ior));
            check({vecs[i].name, ".ready"},  32'(ready),  32'(vecs[i].rdy));
            check({vecs[i].name, ".busy"},   32'(busy),   32'(vecs[i].bsy));
            check({vecs[i].name, ".fault"},  32'(fault),  32'(vecs[i].flt));
        end

        // Supply loss coinciding with SETTLE counter expiry: the block must
        // go straight to OFF with fault and never show the UNHOLD word.
        saw_unhold = 1'b0;
        en = 1'b1;
        repeat (16) begin
            @(negedge clk);
            if (ioring == 8'h04) saw_unhold = 1'b1;
        end
        check("expiry_pre.ioring", 32'(ioring), 32'h02);
        vdd_good = 1'b0;
        repeat (1 + SL) begin
            @(negedge clk);
            if (ioring == 8'h04) saw_unhold = 1'b1;
        end
        check("expiry_loss.ioring", 32'(ioring), 32'h03);
        check("expiry_loss.fault",  32'(fault),  32'h1);
        check("expiry_loss.no_unhold", 32'(saw_unhold), 32'h0);

        vdd_good = 1'b1;
        en       = 1'b0;
        repeat (1 + SL) @(negedge clk);
        check("expiry_clear.fault", 32'(fault), 32'h0);

        check("order.oe_vs_hold", 32'(order_viol), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
